// File: rtl/max_pkg.sv
// Shared types and constants for the signed 16-bit streaming max finder.
package max_pkg;

  typedef logic signed [15:0] sint16_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam sint16_t SINT16_MIN = 16'sh8000;

endpackage

// File: rtl/max2sint16b.sv
// Combinational two-input signed 16-bit max; b_gt flags a strict win for b.
module max2sint16b
  import max_pkg::*;
(
  input  sint16_t a,
  input  sint16_t b,
  output sint16_t y,
  output logic    b_gt
);

  // Strict compare keeps a on ties, so the earliest maximum survives.
  assign b_gt = (b > a);
  assign y    = b_gt ? b : a;

endmodule

// File: rtl/max_stream_seq.sv
// Burst max finder: accepts len signed samples, reports the maximum and the
// index of its first occurrence through a valid/ready result port.
module max_stream_seq
  import max_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  output logic              busy,
  input  logic signed [15:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic signed [15:0] out_max,
  output logic [CNT_W-1:0]  out_idx,
  output logic              out_empty,
  output logic              out_valid,
  input  logic              out_ready
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_rem;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_max_idx;
  sint16_t          r_acc;
  logic             r_first;
  logic             r_empty;
  logic             r_busy;
  logic             r_in_ready;
  logic             r_out_valid;
  sint16_t          w_y;
  logic             w_b_gt;
  logic             w_accept;

  // One comparator shared by every sample of the burst.
  max2sint16b u_max2 (
    .a    (r_acc),
    .b    (in_data),
    .y    (w_y),
    .b_gt (w_b_gt)
  );

  assign w_accept = (r_state == ACCUM) && in_valid;

  // Next-state decode for the burst FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = (len == {CNT_W{1'b0}}) ? DONE : ACCUM;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ACCUM: begin
        if (w_accept && (r_rem == CNT_W'(1))) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = ACCUM;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, datapath and registered handshake flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rem       <= {CNT_W{1'b0}};
      r_idx       <= {CNT_W{1'b0}};
      r_max_idx   <= {CNT_W{1'b0}};
      r_acc       <= 16'sd0;
      r_first     <= 1'b0;
      r_empty     <= 1'b0;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= (w_state_nxt != IDLE);
      r_in_ready  <= (w_state_nxt == ACCUM);
      r_out_valid <= (w_state_nxt == DONE);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_rem     <= len;
            r_idx     <= {CNT_W{1'b0}};
            r_max_idx <= {CNT_W{1'b0}};
            r_first   <= 1'b1;
            r_empty   <= (len == {CNT_W{1'b0}});
            if (len == {CNT_W{1'b0}}) begin
              r_acc <= SINT16_MIN;
            end
          end
        end
        ACCUM: begin
          if (w_accept) begin
            r_rem   <= r_rem - CNT_W'(1);
            r_idx   <= r_idx + CNT_W'(1);
            r_first <= 1'b0;
            // The first sample loads unconditionally; later ones only on a strict win.
            if (r_first) begin
              r_acc     <= in_data;
              r_max_idx <= r_idx;
            end else if (w_b_gt) begin
              r_acc     <= w_y;
              r_max_idx <= r_idx;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_max   = r_acc;
  assign out_idx   = r_max_idx;
  assign out_empty = r_empty;

endmodule

// File: doc/max_stream_seq.md
MAX_STREAM_SEQ -- requirements
Module: max_stream_seq

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 8, the width of the sample-count field (maximum burst 2^CNT_W-1 samples).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a burst; honoured only in IDLE.
REQ-005 The block SHALL have port len, input, CNT_W bits: number of samples in the burst; sampled when start is accepted.
REQ-006 The block SHALL have port busy, output, 1 bit: high in every state other than IDLE.
REQ-007 The block SHALL have port in_data, input, signed 16 bits: sample value.
REQ-008 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the block accepts a sample.
REQ-010 The block SHALL have port out_max, output, signed 16 bits: maximum of the burst.
REQ-011 The block SHALL have port out_idx, output, CNT_W bits: 0-based position of the first occurrence of the maximum.
REQ-012 The block SHALL have port out_empty, output, 1 bit: the burst had len==0.
REQ-013 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-014 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.

Function
REQ-015 The block SHALL implement the FSM states IDLE, ACCUM and DONE.
REQ-016 In IDLE, start=1 with len>0 SHALL latch len into the remaining-count register, clear the sample index and move to ACCUM on the next edge.
REQ-017 In IDLE, start=1 with len==0 SHALL move to DONE with out_max=-32768, out_idx=0 and out_empty=1.
REQ-018 in_ready SHALL be 1 in ACCUM and 0 in every other state; a sample is accepted on a cycle where in_valid && in_ready.
REQ-019 The first accepted sample SHALL load the accumulator and set idx_of_max=0.
REQ-020 Each later accepted sample SHALL replace the accumulator only if in_data > acc (signed compare), so ties keep the earlier index.
REQ-021 Each accepted sample SHALL decrement the remaining count and increment the sample index.
REQ-022 Acceptance of the sample with remaining==1 SHALL move the FSM to DONE, with out_valid=1 on the following cycle (one-cycle latency from the last sample).
REQ-023 In ACCUM, cycles with in_valid=0 SHALL hold all state unchanged; there is no timeout.
REQ-024 In DONE, out_valid SHALL be 1, and out_max, out_idx and out_empty SHALL be held stable until out_valid && out_ready.
REQ-025 On out_valid && out_ready, the FSM SHALL return to IDLE; out_valid SHALL be 0 on the next cycle.
REQ-026 start SHALL be ignored while busy=1, including in the cycle of the DONE->IDLE handshake; a new start is honoured from the first IDLE cycle onward.
REQ-027 Changes on len or start while not in IDLE SHALL have no effect.
REQ-028 Comparison SHALL be full 16-bit two's complement, so -32768 and 32767 are handled correctly, and the accumulator width SHALL equal the sample width.
REQ-029 The count and index registers SHALL be CNT_W bits wide and SHALL never wrap within a burst, because the index is bounded by len-1.

Reset
REQ-030 When reset=1 at a clock edge, the FSM SHALL return to IDLE from any state and discard any partial burst or unconsumed result.
REQ-031 In the cycle after reset, the outputs SHALL be busy=0, in_ready=0, out_valid=0, out_max=0, out_idx=0 and out_empty=0.
REQ-032 reset SHALL take priority over start, in_valid and out_ready asserted in the same cycle.

Structure
REQ-033 A shared package max_pkg SHALL contain the sint16_t typedef, the state enum (IDLE, ACCUM, DONE) and the constant SINT16_MIN=-32768.
REQ-034 A combinational sub-module max2sint16b SHALL be used for the compare; its ports are a, b (sint16_t) and outputs y (the larger value) and b_gt (1 when b > a).
REQ-035 The max2sint16b instance SHALL be the only compare resource in the block, shared across all samples of a burst.

Verification
REQ-036 A bench SHALL drive start with len=3 and samples 5, -7, 12 with in_valid held high, and SHALL check out_max=12, out_idx=2, out_empty=0, and out_valid exactly one cycle after the third sample.
REQ-037 A bench SHALL drive samples -32768, 32767, -1 with len=3, and SHALL check out_max=32767 and out_idx=1 (signed extremes).
REQ-038 A bench SHALL drive ties 4, 9, 9, 2 with len=4, and SHALL check out_max=9 and out_idx=1.
REQ-039 A bench SHALL drive start with len=0, and SHALL check DONE the next cycle with out_empty=1 and out_max=-32768; it SHALL then hold out_ready=0 for 5 cycles and check that the outputs stay stable.
REQ-040 A bench SHALL insert in_valid gaps and toggle start mid-burst, and SHALL check that the result is unchanged and that the start toggles are ignored.
REQ-041 A bench SHALL assert reset after 2 of 4 samples, and SHALL check that the block is in IDLE with all outputs 0; a following burst with len=2 and samples 1, 3 SHALL give out_max=3 and out_idx=1.
